stage1_if_prefetch: RTL and testbench

STAGE1_IF_PREFETCH -- requirements
Module: stage1_if_prefetch

---
 rtl/stage1_if_prefetch.sv | 196 +++++++++++++++++++
 tb/tb_stage1_if_prefetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_if_prefetch.sv
// stage1_if_prefetch: instruction-fetch stage with a small prefetch buffer.
// Requests go out on inst_sram at fetch_pc. Returned words are paired with
// their request PC and queued for decode. A credit rule on outstanding
// requests plus buffer occupancy means the buffer can never overflow.
// Branch redirects flush the buffer, and responses still in flight at that
// moment are dropped.
// Optional feature: define IF_PREFETCH_BYPASS_EN to present a response to
// decode in the same cycle it returns when the buffer is empty.
module stage1_if_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h1C000000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QIDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SUM_W  = CNT_W + 1;

    localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0]  DEPTH_V   = SUM_W'(FIFO_DEPTH);
    localparam logic [QIDX_W-1:0] QLAST     = QIDX_W'(MAX_OUTSTANDING - 1);

    logic                started;
    logic [31:0]         fetch_pc;
    logic [31:0]         pcq_mem [MAX_OUTSTANDING];
    logic [QIDX_W-1:0]   pcq_head;
    logic [QIDX_W-1:0]   pcq_tail;
    logic [OUT_W-1:0]    outstanding;
    logic [OUT_W-1:0]    discard;
    logic [63:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                accept;
    logic                resp_keep;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [63:0]         resp_entry;
    logic [63:0]         bus_raw;
    logic [SUM_W-1:0]    credit_used;

    // The instruction port never writes
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;
    assign inst_sram_addr  = fetch_pc;

    // Every in-flight request already owns a buffer slot, so outstanding + occupancy bounds the buffer
    assign credit_used   = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign inst_sram_req = started && !br_taken
                         && (outstanding < MAX_OUT_V)
                         && (credit_used < DEPTH_V);

    assign accept     = inst_sram_req && inst_sram_addr_ok;
    assign fifo_empty = (fifo_count == '0);
    assign resp_keep  = inst_sram_data_ok && (discard == '0) && !br_taken;
    assign resp_entry = {inst_sram_rdata, pcq_mem[pcq_head]};

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass_hit;

    // A kept response can go straight to decode when nothing older is waiting in the buffer
    assign bypass_hit     = resp_keep && fifo_empty;
    assign fs_to_ds_valid = !br_taken && (!fifo_empty || bypass_hit);
    assign bus_raw        = fifo_empty ? resp_entry : fifo_mem[rd_ptr];
    assign push           = resp_keep && !(bypass_hit && ds_allow_in);
`else
    // Responses always pass through the buffer, giving one cycle from data_ok to valid
    assign fs_to_ds_valid = !fifo_empty && !br_taken;
    assign bus_raw        = fifo_mem[rd_ptr];
    assign push           = resp_keep;
`endif

    assign pop          = fs_to_ds_valid && ds_allow_in && !fifo_empty;
    assign fs_to_ds_bus = fs_to_ds_valid ? bus_raw : 64'd0;

    // Hold off the first request until one clock edge has passed after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Fetch PC: redirect on branch, otherwise step one word per accepted request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
        end else if (br_taken) begin
            fetch_pc <= br_target;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // PC queue storage: remember each accepted request's address in issue order
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_tail] <= fetch_pc;
        end
    end

    // PC queue pointers: every response, kept or dropped, retires the oldest entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcq_head <= '0;
            pcq_tail <= '0;
        end else begin
            if (accept) begin
                pcq_tail <= (pcq_tail == QLAST) ? '0 : pcq_tail + QIDX_W'(1);
            end
            if (inst_sram_data_ok) begin
                pcq_head <= (pcq_head == QLAST) ? '0 : pcq_head + QIDX_W'(1);
            end
        end
    end

    // Outstanding count: +1 on accept, -1 on response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
        end else begin
            case ({accept, inst_sram_data_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Discard count: responses still owed from before a redirect are dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard <= '0;
        end else if (br_taken) begin
            discard <= outstanding - (inst_sram_data_ok ? OUT_W'(1) : OUT_W'(0));
        end else if (inst_sram_data_ok && (discard != '0)) begin
            discard <= discard - OUT_W'(1);
        end
    end

    // Buffer storage write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= resp_entry;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (br_taken) begin
            rd_ptr     <= wr_ptr;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_if_prefetch.sv
// tb_stage1_if_prefetch: randomized bench for stage1_if_prefetch.
// The bench plays the instruction memory. Its reference model tracks the
// stream of PCs decode should see: one entry per accepted fetch, and the
// whole list is cleared on a redirect.
module tb_stage1_if_prefetch;

    localparam logic [31:0] RESET_PC        = 32'h1C000000;
    localparam int          FIFO_DEPTH      = 4;
    localparam int          MAX_OUTSTANDING = 2;

    logic        clk;
    logic        resetn;
    logic        ds_allow_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int          errors;
    int          checks;

    logic [31:0] pending[$];
    logic [31:0] exp_pcs[$];
    logic [31:0] accept_log[$];
    logic [31:0] deliver_log[$];
    int          stale;
    logic [31:0] exp_fetch;

    stage1_if_prefetch #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allow_in       (ds_allow_in),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word the memory returns for a given address
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h13579BDF;
    endfunction

    // Single comparison point: count it and report a mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model step for the upcoming clock edge (called between edges)
    task automatic observe();
        logic acc;
        acc = inst_sram_req && inst_sram_addr_ok;
        if (br_taken) begin
            checkOutput("br_req", 64'(inst_sram_req), 64'd0);
            checkOutput("br_valid", 64'(fs_to_ds_valid), 64'd0);
        end
        if (acc) begin
            checkOutput("fetch_addr", 64'(inst_sram_addr), 64'(exp_fetch));
            checkOutput("credit_out", 64'(pending.size() < MAX_OUTSTANDING), 64'd1);
            checkOutput("credit_fifo", 64'((exp_pcs.size() + stale) < FIFO_DEPTH), 64'd1);
        end
        if (inst_sram_data_ok) begin
            void'(pending.pop_front());
            if (!br_taken && stale > 0) stale--;
        end
        if (fs_to_ds_valid && ds_allow_in) begin
            if (exp_pcs.size() == 0) begin
                checkOutput("deliver_any", 64'(fs_to_ds_valid), 64'd0);
            end else begin
                logic [31:0] e;
                e = exp_pcs.pop_front();
                checkOutput("deliver_pc", 64'(fs_to_ds_bus[31:0]), 64'(e));
                checkOutput("deliver_inst", 64'(fs_to_ds_bus[63:32]), 64'(inst_of(e)));
            end
            deliver_log.push_back(fs_to_ds_bus[31:0]);
        end
        if (br_taken) begin
            exp_pcs.delete();
            exp_fetch = br_target;
            stale = pending.size();
        end
        if (acc) begin
            pending.push_back(inst_sram_addr);
            exp_pcs.push_back(exp_fetch);
            accept_log.push_back(inst_sram_addr);
            exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    // One cycle: drive inputs just after the edge, then run the model between edges
    task automatic applyStimulus(input int p_addr, input int p_data, input int p_allow,
                                 input logic do_br, input logic [31:0] target);
        @(posedge clk);
        #1;
        inst_sram_addr_ok = ($urandom_range(99) < p_addr);
        inst_sram_data_ok = (pending.size() > 0) && ($urandom_range(99) < p_data);
        inst_sram_rdata   = inst_sram_data_ok ? inst_of(pending[0]) : $urandom;
        ds_allow_in       = ($urandom_range(99) < p_allow);
        br_taken          = do_br;
        br_target         = target;
        @(negedge clk);
        observe();
    endtask

    // Assert reset between clock edges, check outputs at once, release mid-cycle
    task automatic doReset();
        @(posedge clk);
        #3;
        resetn            = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        ds_allow_in       = 1'b0;
        br_taken          = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(fs_to_ds_valid), 64'd0);
        checkOutput("rst_req", 64'(inst_sram_req), 64'd0);
        checkOutput("rst_bus", fs_to_ds_bus, 64'd0);
        checkOutput("rst_addr", 64'(inst_sram_addr), 64'(RESET_PC));
        pending.delete();
        exp_pcs.delete();
        accept_log.delete();
        deliver_log.delete();
        stale     = 0;
        exp_fetch = RESET_PC;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        checkOutput("rel_req", 64'(inst_sram_req), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic seen_resp;
        logic next_resp;
        logic last_br;
        logic same_cycle_valid;
        errors            = 0;
        checks            = 0;
        stale             = 0;
        exp_fetch         = RESET_PC;
        resetn            = 1'b0;
        ds_allow_in       = 1'b0;
        br_taken          = 1'b0;
        br_target         = 32'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
`ifdef IF_PREFETCH_BYPASS_EN
        same_cycle_valid = 1'b1;
`else
        same_cycle_valid = 1'b0;
`endif
        doReset();
        checkOutput("tie_wr", 64'(inst_sram_wr), 64'd0);
        checkOutput("tie_size", 64'(inst_sram_size), 64'd2);
        checkOutput("tie_wstrb", 64'(inst_sram_wstrb), 64'd0);
        checkOutput("tie_wdata", 64'(inst_sram_wdata), 64'd0);

        // Streaming fetch with immediate accept and one-cycle responses
        seen_resp = 1'b0;
        next_resp = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(100, 100, 100, 1'b0, 32'd0);
            if (next_resp) begin
                if (!same_cycle_valid) checkOutput("lat_next", 64'(fs_to_ds_valid), 64'd1);
                next_resp = 1'b0;
            end
            if (!seen_resp && inst_sram_data_ok) begin
                checkOutput("lat_same", 64'(fs_to_ds_valid), 64'(same_cycle_valid));
                seen_resp = 1'b1;
                next_resp = 1'b1;
            end
        end
        checkOutput("stream_a0", 64'(accept_log[0]), 64'h1C000000);
        checkOutput("stream_a1", 64'(accept_log[1]), 64'h1C000004);
        checkOutput("stream_a2", 64'(accept_log[2]), 64'h1C000008);
        checkOutput("stream_d0", 64'(deliver_log[0]), 64'h1C000000);

        // Decode stalled: buffer fills and requests stop, then drains in order
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(100, 100, 0, 1'b0, 32'd0);
        checkOutput("stall_accepts", 64'(accept_log.size()), 64'(FIFO_DEPTH));
        checkOutput("stall_req", 64'(inst_sram_req), 64'd0);
        for (int i = 0; i < 8; i++) applyStimulus(100, 100, 100, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput("stall_order", 64'(deliver_log[i]), 64'(RESET_PC + 32'(4 * i)));

        // Redirect with two requests in flight
        doReset();
        applyStimulus(100, 0, 100, 1'b0, 32'd0);
        applyStimulus(100, 0, 100, 1'b0, 32'd0);
        applyStimulus(100, 0, 100, 1'b0, 32'd0);
        checkOutput("max_out_req", 64'(inst_sram_req), 64'd0);
        applyStimulus(100, 0, 100, 1'b1, 32'h1C000100);
        for (int i = 0; i < 10; i++) applyStimulus(100, 100, 100, 1'b0, 32'd0);
        checkOutput("br_first_pc", 64'(deliver_log[0]), 64'h1C000100);

        // Redirect coincident with a response while three entries are buffered
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(100, 100, 0, 1'b0, 32'd0);
        applyStimulus(100, 100, 0, 1'b1, 32'h1C000200);
        checkOutput("full_credit_req", 64'(inst_sram_req), 64'd0);
        checkOutput("br_resp_valid", 64'(fs_to_ds_valid), 64'd0);
        applyStimulus(100, 100, 0, 1'b0, 32'd0);
        checkOutput("flush_empty", 64'(fs_to_ds_valid), 64'd0);
        for (int i = 0; i < 8; i++) applyStimulus(100, 100, 100, 1'b0, 32'd0);
        checkOutput("flush_first_pc", 64'(deliver_log[0]), 64'h1C000200);

        // Memory refuses requests for five cycles
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 100, 100, 1'b0, 32'd0);
            checkOutput("hold_req", 64'(inst_sram_req), 64'd1);
            checkOutput("hold_addr", 64'(inst_sram_addr), 64'(RESET_PC));
        end
        applyStimulus(100, 100, 100, 1'b0, 32'd0);
        applyStimulus(0, 100, 100, 1'b0, 32'd0);
        checkOutput("hold_accepts", 64'(accept_log.size()), 64'd1);
        checkOutput("hold_next_addr", 64'(inst_sram_addr), 64'(RESET_PC + 32'd4));

        // Reset pulsed in the middle of traffic
        for (int i = 0; i < 20; i++) applyStimulus(80, 70, 60, 1'b0, 32'd0);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(100, 100, 100, 1'b0, 32'd0);
        checkOutput("refetch_pc", 64'(accept_log[0]), 64'(RESET_PC));

        // Random traffic with occasional redirects, including near address wrap
        last_br = 1'b0;
        for (int blk = 0; blk < 4; blk++) begin
            int pa;
            int pd;
            int pl;
            pa = $urandom_range(30, 100);
            pd = $urandom_range(30, 100);
            pl = $urandom_range(20, 100);
            for (int i = 0; i < 100; i++) begin
                logic [31:0] r;
                logic [31:0] t;
                logic        do_br;
                r     = $urandom;
                do_br = (r[4:0] == 5'd0) && !last_br;
                r     = $urandom;
                t     = {r[31:2], 2'b00};
                if (r[5:2] == 4'd0) t = 32'hFFFFFFF0;
                applyStimulus(pa, pd, pl, do_br, t);
                last_br = do_br;
            end
        end

        // Drain: no new requests, everything owed must reach decode
        for (int i = 0; i < 20; i++) applyStimulus(0, 100, 100, 1'b0, 32'd0);
        checkOutput("drain_left", 64'(exp_pcs.size()), 64'd0);
        checkOutput("drain_valid", 64'(fs_to_ds_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
